// File: rtl/spi_mem_master_if.sv
// Request/response bus between on-chip logic and spi_mem_master.
// Ports: req_* request handshake, rsp_* completion, busy status.
interface spi_mem_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_write,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, busy
  );
endinterface

// File: rtl/spi_mem_master.sv
// SPI mode-0 master issuing 16-bit {addr,rw,data} frames to spiMemory.
// Ports: i_clk, i_reset (sync high), bus (slave modport), SPI pins.
module spi_mem_master #(
  parameter int CLK_DIV = 5,
  parameter int GAP_CYC = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  spi_mem_master_if.slave  bus,
  output logic             o_sclk_pin,
  output logic             o_cs_pin,
  output logic             o_mosi_pin,
  input  logic             i_miso_pin
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP
  } state_t;

  state_t      r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic [GW-1:0] r_gap, w_gap;
  logic [4:0]  r_bit, w_bit;
  logic [15:0] r_tx, w_tx;
  logic [7:0]  r_rx, w_rx;
  logic        r_rd, w_rd;
  logic        r_rsp_valid, w_rsp_valid;
  logic [7:0]  r_rdata, w_rdata;
  logic        w_last;
  logic        w_frame;

  assign w_last = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_gap       <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_div       <= w_div;
      r_gap       <= w_gap;
      r_bit       <= w_bit;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_rd        <= w_rd;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_div       = r_div;
    w_gap       = r_gap;
    w_bit       = r_bit;
    w_tx        = r_tx;
    w_rx        = r_rx;
    w_rd        = r_rd;
    w_rsp_valid = 1'b0;
    w_rdata     = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state = S_SETUP;
          w_div   = '0;
          w_bit   = '0;
          w_rd    = ~bus.req_write;
          w_tx    = {bus.req_addr, ~bus.req_write,
                     bus.req_write ? bus.req_wdata : 8'h00};
        end
      end
      S_SETUP: begin
        if (w_last) begin
          w_state = S_HIGH;
          w_div   = '0;
        end else begin
          w_div = r_div + DW'(1);
        end
      end
      S_HIGH: begin
        if (w_last) begin
          // sample miso at the end of HIGH; shift tx so mosi
          // changes as sclk falls
          w_state = S_LOW;
          w_div   = '0;
          w_rx    = {r_rx[6:0], i_miso_pin};
          w_tx    = {r_tx[14:0], 1'b0};
          w_bit   = r_bit + 5'd1;
        end else begin
          w_div = r_div + DW'(1);
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_div = '0;
          if (r_bit == 5'd16) begin
            w_state     = S_GAP;
            w_gap       = '0;
            w_rsp_valid = 1'b1;
            w_rdata     = r_rd ? r_rx : 8'h00;
          end else begin
            w_state = S_HIGH;
          end
        end else begin
          w_div = r_div + DW'(1);
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYC - 1)) begin
          w_state = S_IDLE;
        end else begin
          w_gap = r_gap + GW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_frame = (r_state == S_SETUP) ||
                   (r_state == S_HIGH) ||
                   (r_state == S_LOW);

  assign o_cs_pin      = ~w_frame;
  assign o_sclk_pin    = (r_state == S_HIGH);
  assign o_mosi_pin    = w_frame & r_tx[15];
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master with a behavioural spiMemory slave.
// Checks pins, frame bits, timing, response data and reset abort.
module tb_spi_mem_master;

  localparam int CLK_DIV = 5;
  localparam int GAP_CYC = 8;
  localparam int CS_LOW  = 33 * CLK_DIV;
  localparam int LAT     = 1 + CS_LOW;

  logic clk = 1'b0;
  logic reset;
  logic sclk, cs, mosi;
  logic miso = 1'b0;

  always #5 clk = ~clk;

  spi_mem_master_if bus ();

  spi_mem_master #(
    .CLK_DIV (CLK_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .bus        (bus),
    .o_sclk_pin (sclk),
    .o_cs_pin   (cs),
    .o_mosi_pin (mosi),
    .i_miso_pin (miso)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural spiMemory slave
  logic [7:0]  mem [128];
  logic [15:0] s_sh = '0;
  logic [15:0] s_frame = '0;
  int          s_cnt = 0;
  logic [6:0]  s_addr = '0;
  logic        s_rd = 1'b0;

  always @(negedge cs) begin
    s_cnt = 0;
    s_sh  = '0;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      s_sh = {s_sh[14:0], mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        s_addr = s_sh[7:1];
        s_rd   = s_sh[0];
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs && s_rd && s_cnt >= 8 && s_cnt < 16)
      miso = mem[s_addr][15 - s_cnt];
  end

  always @(posedge cs) begin
    miso    = 1'b0;
    s_frame = s_sh;
    if (s_cnt == 16 && !s_rd)
      mem[s_addr] = s_sh[7:0];
  end

  // pin/handshake monitors
  int   c_sclk = 0, c_cslow = 0, c_rsp = 0, c_rdybad = 0;
  logic sclk_q = 1'b0;

  always @(negedge clk) begin
    if (cs === 1'b0) c_cslow++;
    if (bus.rsp_valid === 1'b1) c_rsp++;
    if (sclk === 1'b1 && sclk_q !== 1'b1) c_sclk++;
    sclk_q = sclk;
    if (reset === 1'b0 && bus.req_ready === bus.busy)
      c_rdybad++;
  end

  task automatic clr();
    c_sclk  = 0;
    c_cslow = 0;
    c_rsp   = 0;
  endtask

  task automatic issue(input logic wr,
                       input logic [6:0] a,
                       input logic [7:0] d);
    int i;
    @(negedge clk);
    #1;
    clr();
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (i = 0; i < 400; i++) begin
      if (bus.req_ready) break;
      @(negedge clk);
    end
    if (i == 400) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~a;
    bus.req_wdata = ~d;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (i == 60) check("idle_timeout", 0, 1);
  endtask

  int lat;
  int hi;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'h7F;
    bus.req_wdata = 8'hFF;

    // 1: reset held 3 cycles, with a competing request
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 8'h00);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_noaccept", bus.busy, 0);

    // 2: write 0x2A <- 0xA5
    issue(1'b1, 7'h2A, 8'hA5);
    wait_rsp(lat);
    check("wr_lat", lat, LAT);
    check("wr_rdata", bus.rsp_rdata, 8'h00);
    wait_idle();
    check("wr_rsp_cnt", c_rsp, 1);
    check("wr_sclk_cnt", c_sclk, 16);
    check("wr_cs_low", c_cslow, CS_LOW);
    check("wr_mosi_hi", s_frame[15:8], 8'h54);
    check("wr_mosi_lo", s_frame[7:0], 8'hA5);
    check("wr_mem", mem[7'h2A], 8'hA5);

    // 3: read 0x2A, slave returns 0x3C
    mem[7'h2A] = 8'h3C;
    issue(1'b0, 7'h2A, 8'hFF);
    wait_rsp(lat);
    check("rd_lat", lat, LAT);
    check("rd_rdata", bus.rsp_rdata, 8'h3C);
    wait_idle();
    check("rd_rsp_cnt", c_rsp, 1);
    check("rd_sclk_cnt", c_sclk, 16);
    check("rd_mosi", s_frame, 16'h5500);
    check("rd_hold", bus.rsp_rdata, 8'h3C);

    // 4: req_valid held across two back-to-back reads
    mem[7'h33] = 8'h96;
    @(negedge clk);
    #1;
    clr();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 7'h33;
    bus.req_wdata = 8'h00;
    wait_rsp(lat);
    check("b2b_lat1", lat, LAT);
    check("b2b_rd1", bus.rsp_rdata, 8'h96);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (!cs) break;
      hi++;
      @(negedge clk);
    end
    check("b2b_gap", hi, GAP_CYC + 1);
    #1;
    bus.req_valid = 1'b0;
    mem[7'h33] = 8'h4B;
    wait_rsp(lat);
    check("b2b_rd2", bus.rsp_rdata, 8'h4B);
    wait_idle();
    check("b2b_rsp_cnt", c_rsp, 2);

    // 5: reset in the 5th HIGH phase aborts the frame
    issue(1'b1, 7'h11, 8'h99);
    for (int i = 0; i < 200 && c_sclk < 5; i++)
      @(negedge clk);
    check("ab_sclk5", sclk, 1);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("ab_cs", cs, 1);
    check("ab_sclk", sclk, 0);
    check("ab_busy", bus.busy, 0);
    check("ab_ready", bus.req_ready, 1);
    #1;
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("ab_no_rsp", c_rsp, 0);
    check("ab_no_wr", mem[7'h11], 8'h00);
    issue(1'b1, 7'h11, 8'h66);
    wait_rsp(lat);
    check("ab_after_lat", lat, LAT);
    wait_idle();
    check("ab_after_mem", mem[7'h11], 8'h66);
    check("ab_after_rsp", c_rsp, 1);

    // 6: write then read back through the slave
    issue(1'b1, 7'h05, 8'hC3);
    wait_rsp(lat);
    wait_idle();
    check("rt_mem", mem[7'h05], 8'hC3);
    issue(1'b0, 7'h05, 8'h00);
    wait_rsp(lat);
    check("rt_rdata", bus.rsp_rdata, 8'hC3);
    check("rt_mosi", s_frame, 16'h0B00);
    wait_idle();

    check("ready_vs_busy", c_rdybad, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
